ma_channel_scheduler: RTL and testbench

- Time-multiplexes one shared 8-bit signed moving-average datapath across NUM_CH independent input channels.
- Round-robin arbitration accepts at most one sample per cycle.
- Keeps per-channel window history and a per-channel running sum.
- Emits each channel's averaged result tagged with its channel index. Sits between the per-channel sample sources and the downstream consumer.

---
 rtl/ma_channel_scheduler.sv | 111 +++++++++++
 tb/tb_ma_channel_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ma_channel_scheduler.sv
// rtl/ma_channel_scheduler.sv - round-robin multi-channel moving-average scheduler (optional MA_SCHED_ROUND_EN)
module ma_channel_scheduler #(
    parameter int NUM_CH = 4,
    parameter int WINDOW = 4,
    parameter int DATA_W = 8
) (
    input  logic                        system1000,
    input  logic                        system1000_rst,
    input  logic [NUM_CH-1:0]           req_valid,
    input  logic [NUM_CH*DATA_W-1:0]    req_data,
    output logic [NUM_CH-1:0]           req_ready,
    output logic                        out_valid,
    output logic signed [DATA_W-1:0]    out_data,
    output logic [$clog2(NUM_CH)-1:0]   out_ch,
    input  logic                        out_ready
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int WIN_W = $clog2(WINDOW);
    localparam int SUM_W = DATA_W + WIN_W + 1;

    logic signed [DATA_W-1:0] hist [NUM_CH][WINDOW];
    logic signed [SUM_W-1:0]  sum  [NUM_CH];
    logic [WIN_W-1:0]         wp   [NUM_CH];
    logic [CH_W-1:0]          last_grant;

    logic                     stall;
    logic                     found;
    logic [NUM_CH-1:0]        grant;
    logic [CH_W-1:0]          grant_idx;
    int                       idx;

    logic signed [DATA_W-1:0] sample;
    logic signed [DATA_W-1:0] oldest;
    logic signed [SUM_W-1:0]  sum_new;
    logic signed [DATA_W-1:0] avg;

    assign stall = out_valid && !out_ready;

    // Search starts just past the last winner so every requester is served within NUM_CH grants.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        if (!stall) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                idx = (int'(last_grant) + k) % NUM_CH;
                if (!found && req_valid[idx]) begin
                    found          = 1'b1;
                    grant[idx]     = 1'b1;
                    grant_idx      = CH_W'(idx);
                end
            end
        end
    end

    assign req_ready = grant;

    assign sample  = req_data[grant_idx*DATA_W +: DATA_W];
    assign oldest  = hist[grant_idx][wp[grant_idx]];
    assign sum_new = sum[grant_idx]
                   + {{(SUM_W-DATA_W){sample[DATA_W-1]}}, sample}
                   - {{(SUM_W-DATA_W){oldest[DATA_W-1]}}, oldest};

`ifdef MA_SCHED_ROUND_EN
    localparam logic signed [SUM_W:0] MAX_V = (SUM_W+1)'((1 << (DATA_W-1)) - 1);
    localparam logic signed [SUM_W:0] MIN_V = (SUM_W+1)'(-(1 << (DATA_W-1)));

    logic signed [SUM_W:0] rnd;
    logic signed [SUM_W:0] rnd_sh;

    assign rnd    = {sum_new[SUM_W-1], sum_new} + (SUM_W+1)'(WINDOW/2);
    assign rnd_sh = rnd >>> WIN_W;

    always_comb begin
        avg = DATA_W'(rnd_sh);
        if (rnd_sh > MAX_V)
            avg = DATA_W'(MAX_V);
        else if (rnd_sh < MIN_V)
            avg = DATA_W'(MIN_V);
    end
`else
    // Average of in-range samples always fits DATA_W, so truncation is lossless.
    assign avg = DATA_W'(sum_new >>> WIN_W);
`endif

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int w = 0; w < WINDOW; w++)
                    hist[c][w] <= '0;
                sum[c] <= '0;
                wp[c]  <= '0;
            end
            last_grant <= CH_W'(NUM_CH-1);
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
        end else if (found) begin
            hist[grant_idx][wp[grant_idx]] <= sample;
            wp[grant_idx]                  <= wp[grant_idx] + 1'b1;
            sum[grant_idx]                 <= sum_new;
            last_grant                     <= grant_idx;
            out_valid                      <= 1'b1;
            out_data                       <= avg;
            out_ch                         <= grant_idx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ma_channel_scheduler.sv
// tb/tb_ma_channel_scheduler.sv - randomized bench with behavioural model for ma_channel_scheduler
module tb_ma_channel_scheduler;
    localparam int NUM_CH = 4;
    localparam int WINDOW = 4;
    localparam int DATA_W = 8;
    localparam int CH_W   = $clog2(NUM_CH);

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [NUM_CH-1:0]          req_valid = '0;
    logic [NUM_CH*DATA_W-1:0]   req_data = '0;
    logic [NUM_CH-1:0]          req_ready;
    logic                       out_valid;
    logic signed [DATA_W-1:0]   out_data;
    logic [CH_W-1:0]            out_ch;
    logic                       out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    // Model state: recent samples per channel, newest last.
    int win [NUM_CH][WINDOW];
    int m_last;
    int m_valid, m_data, m_ch;
    int last_rr;

    ma_channel_scheduler #(.NUM_CH(NUM_CH), .WINDOW(WINDOW), .DATA_W(DATA_W)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ch         (out_ch),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int floor_div(input int s, input int d);
        int q;
        q = s / d;
        if ((s % d) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    function automatic int model_avg(input int s);
`ifdef MA_SCHED_ROUND_EN
        int q;
        q = floor_div(s + WINDOW/2, WINDOW);
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
`else
        return floor_div(s, WINDOW);
`endif
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++)
            for (int w = 0; w < WINDOW; w++)
                win[c][w] = 0;
        m_last  = NUM_CH - 1;
        m_valid = 0;
        m_data  = 0;
        m_ch    = 0;
    endtask

    function automatic logic [NUM_CH*DATA_W-1:0] pack(input int ch, input int val);
        logic [NUM_CH*DATA_W-1:0] v;
        v = '0;
        v[ch*DATA_W +: DATA_W] = DATA_W'(val);
        return v;
    endfunction

    // One cycle: drive at negedge, check grant, advance model, check outputs at next negedge.
    task automatic step(input logic [NUM_CH-1:0] v, input logic [NUM_CH*DATA_W-1:0] d,
                        input logic ordy, input logic r);
        int g;
        int s;
        logic [NUM_CH-1:0] exp_rr;
        req_valid = v;
        req_data  = d;
        out_ready = ordy;
        rst       = r;
        #1;
        g = -1;
        if (!(m_valid != 0 && !ordy)) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                if (g < 0 && v[(m_last + k) % NUM_CH]) g = (m_last + k) % NUM_CH;
            end
        end
        exp_rr = '0;
        if (g >= 0) exp_rr[g] = 1'b1;
        last_rr = int'(req_ready);
        chk("req_ready", int'(req_ready), int'(exp_rr));
        if (r) begin
            model_reset();
        end else if (g >= 0) begin
            for (int w = 0; w < WINDOW-1; w++) win[g][w] = win[g][w+1];
            win[g][WINDOW-1] = int'($signed(d[g*DATA_W +: DATA_W]));
            s = 0;
            for (int w = 0; w < WINDOW; w++) s += win[g][w];
            m_valid = 1;
            m_data  = model_avg(s);
            m_ch    = g;
            m_last  = g;
        end else if (m_valid != 0 && ordy) begin
            m_valid = 0;
        end
        @(negedge clk);
        chk("out_valid", int'(out_valid), m_valid);
        chk("out_data", int'(out_data), m_data);
        chk("out_ch", int'(out_ch), m_ch);
    endtask

    initial begin
        logic [NUM_CH*DATA_W-1:0] rd;
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_out_ch", int'(out_ch), 0);

        // ch0 warm-up with 8s
        for (int i = 0; i < 4; i++) begin
            step(4'b0001, pack(0, 8), 1'b1, 1'b0);
            chk("warmup_data", int'(out_data), 2 * (i + 1));
            chk("warmup_ch", int'(out_ch), 0);
        end

        // single negative sample on ch1
        step(4'b0010, pack(1, -1), 1'b1, 1'b0);
`ifdef MA_SCHED_ROUND_EN
        chk("neg_one_avg", int'(out_data), 0);
`else
        chk("neg_one_avg", int'(out_data), -1);
`endif

        // ch2 full-scale positive then most-negative
        for (int i = 0; i < 5; i++) step(4'b0100, pack(2, 127), 1'b1, 1'b0);
        chk("max_avg", int'(out_data), 127);
        step(4'b0100, pack(2, -128), 1'b1, 1'b0);
        chk("mixed_avg", int'(out_data), 63);

        // round-robin with all requesting after a fresh reset
        step('0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            rd = NUM_CH*DATA_W'($urandom());
            step(4'b1111, rd, 1'b1, 1'b0);
            chk("rr_order", last_rr, 1 << (i % NUM_CH));
        end

        // stall: output held, no grants, then resume at ch2
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, '0, 1'b0, 1'b0);
            chk("stall_ready", last_rr, 0);
            chk("stall_ch", int'(out_ch), 1);
            chk("stall_valid", int'(out_valid), 1);
        end
        step(4'b1111, '0, 1'b1, 1'b0);
        chk("resume_grant", last_rr, 4);

        // reset mid-stream clears history
        step('0, '0, 1'b1, 1'b1);
        step(4'b0001, pack(0, 4), 1'b1, 1'b0);
        step(4'b0001, pack(0, 4), 1'b1, 1'b0);
        step(4'b0001, pack(0, 4), 1'b1, 1'b1);
        chk("midreset_valid", int'(out_valid), 0);
        step(4'b0001, pack(0, 4), 1'b1, 1'b0);
        chk("midreset_data", int'(out_data), 1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                case ($urandom_range(0, 3))
                    0:       rd[c*DATA_W +: DATA_W] = 8'h7f;
                    1:       rd[c*DATA_W +: DATA_W] = 8'h80;
                    default: rd[c*DATA_W +: DATA_W] = DATA_W'($urandom());
                endcase
            end
            step(NUM_CH'($urandom()), rd, ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 199) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
